// File: rtl/gb_mmio_pkg.sv
// Shared MMIO constants and DMA sequencer types for the gameboy memory map.
package gb_mmio_pkg;

    localparam logic [15:0] MMIO_DMA      = 16'hFF46;
    localparam logic [15:0] MEM_OAM_START = 16'hFE00;
    localparam int          OAM_LEN       = 160;
    localparam logic [15:0] HRAM_START    = 16'hFF80;
    localparam logic [15:0] HRAM_END      = 16'hFFFE;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        READ  = 2'd2,
        WRITE = 2'd3
    } dma_state_t;

    // Echo RAM (0xE000-0xFDFF) aliases WRAM, so source pages at or above 0xE0
    // are folded down by 0x20 before they reach the bus decode.
    function automatic logic [7:0] src_fold(input logic [7:0] src);
        return (src >= 8'hE0) ? (src - 8'h20) : src;
    endfunction

endpackage

// File: rtl/oam_dma_arbiter.sv
// OAM DMA engine and bus owner: forwards CPU accesses while idle, and while a
// transfer runs it alternates READ/WRITE cycles copying LEN bytes into OAM,
// locking the CPU off the external bus.
module oam_dma_arbiter
    import gb_mmio_pkg::*;
#(
    parameter int          LEN      = OAM_LEN,
    parameter logic [15:0] OAM_BASE = MEM_OAM_START
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] cpu_addr,
    input  logic [7:0]  cpu_wdata,
    input  logic        cpu_we,
    input  logic        cpu_re,
    input  logic [7:0]  bus_rdata,
    output logic [15:0] bus_addr,
    output logic [7:0]  bus_wdata,
    output logic        bus_we,
    output logic        bus_re,
    output logic [7:0]  cpu_rdata,
    output logic        cpu_mem_disable,
    output logic        dma_busy
);

    localparam logic [7:0] LAST_IDX = 8'(LEN - 1);

    dma_state_t  state_reg;
    logic [7:0]  src_reg;
    logic [7:0]  idx_reg;
    logic [7:0]  data_reg;
    logic        busy_reg;

    logic        trigger;
    logic [7:0]  src_eff;

    // A DMA register write restarts the engine from any state.
    assign trigger = cpu_we && (cpu_addr == MMIO_DMA);
    assign src_eff = src_fold(src_reg);

    // Sequencer: START dead cycle, then READ/WRITE pairs until the last OAM byte.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
            src_reg   <= 8'h00;
            idx_reg   <= 8'h00;
            data_reg  <= 8'h00;
            busy_reg  <= 1'b0;
        end else if (trigger) begin
            src_reg   <= cpu_wdata;
            idx_reg   <= 8'h00;
            state_reg <= START;
            busy_reg  <= 1'b1;
        end else begin
            case (state_reg)
                IDLE: begin
                    busy_reg <= 1'b0;
                end
                START: begin
                    state_reg <= READ;
                end
                READ: begin
                    data_reg  <= bus_rdata;
                    state_reg <= WRITE;
                end
                WRITE: begin
                    if (idx_reg == LAST_IDX) begin
                        state_reg <= IDLE;
                        busy_reg  <= 1'b0;
                    end else begin
                        idx_reg   <= idx_reg + 8'd1;
                        state_reg <= READ;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                    busy_reg  <= 1'b0;
                end
            endcase
        end
    end

    // Bus mux: CPU pass-through when idle, DMA-generated cycles otherwise.
    always_comb begin
        bus_addr  = cpu_addr;
        bus_wdata = cpu_wdata;
        bus_we    = 1'b0;
        bus_re    = 1'b0;
        case (state_reg)
            IDLE: begin
                bus_we = cpu_we;
                bus_re = cpu_re;
            end
            READ: begin
                bus_addr = {src_eff, idx_reg};
                bus_re   = 1'b1;
            end
            WRITE: begin
                bus_addr  = OAM_BASE + {8'h00, idx_reg};
                bus_wdata = data_reg;
                bus_we    = 1'b1;
            end
            default: begin
                bus_we = 1'b0;
                bus_re = 1'b0;
            end
        endcase
    end

    // CPU read return: the DMA register is always visible; other bus reads see
    // open-bus 0xFF while the engine owns the bus. High RAM lives inside the
    // CPU core and never reaches this port.
    always_comb begin
        cpu_rdata = bus_rdata;
        if (cpu_addr == MMIO_DMA) begin
            cpu_rdata = src_reg;
        end else if (state_reg != IDLE) begin
            cpu_rdata = 8'hFF;
        end
    end

    assign dma_busy        = busy_reg;
    assign cpu_mem_disable = busy_reg;

endmodule

// File: tb/tb_oam_dma_arbiter.sv
// Scoreboard bench for oam_dma_arbiter: a behavioural memory answers the bus,
// expected DMA bus cycles are queued at trigger time and a monitor pops them.
module tb_oam_dma_arbiter;

    logic        clk;
    logic        rst;
    logic [15:0] cpu_addr;
    logic [7:0]  cpu_wdata;
    logic        cpu_we;
    logic        cpu_re;
    logic [7:0]  bus_rdata;
    logic [15:0] bus_addr;
    logic [7:0]  bus_wdata;
    logic        bus_we;
    logic        bus_re;
    logic [7:0]  cpu_rdata;
    logic        cpu_mem_disable;
    logic        dma_busy;

    oam_dma_arbiter dut (
        .clk             (clk),
        .rst             (rst),
        .cpu_addr        (cpu_addr),
        .cpu_wdata       (cpu_wdata),
        .cpu_we          (cpu_we),
        .cpu_re          (cpu_re),
        .bus_rdata       (bus_rdata),
        .bus_addr        (bus_addr),
        .bus_wdata       (bus_wdata),
        .bus_we          (bus_we),
        .bus_re          (bus_re),
        .cpu_rdata       (cpu_rdata),
        .cpu_mem_disable (cpu_mem_disable),
        .dma_busy        (dma_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Bus decode stand-in: same-cycle read data, write on the clock edge.
    logic [7:0] mem [0:65535];
    assign bus_rdata = mem[bus_addr];
    always @(posedge clk) begin
        if (bus_we) mem[bus_addr] <= bus_wdata;
    end

    typedef struct {
        logic [15:0] addr;
        logic        we;
        logic [7:0]  data;
    } bus_op_t;

    bus_op_t    exp_q[$];
    logic [7:0] model [0:65535];
    int         checks = 0;
    int         passed = 0;
    int         busy_total = 0;
    int         e1_seen = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, got, exp);
    endtask

    function automatic logic [7:0] fold(input logic [7:0] s);
        return (s >= 8'hE0) ? s - 8'h20 : s;
    endfunction

    // Drive a one-cycle CPU write starting now (caller sits just after an edge).
    task automatic cpu_write(input logic [15:0] a, input logic [7:0] d);
        cpu_addr = a; cpu_wdata = d; cpu_we = 1'b1;
        @(posedge clk); #1;
        cpu_we = 1'b0;
    endtask

    task automatic preload(input logic [15:0] a, input logic [7:0] d);
        cpu_write(a, d);
        model[a] = d;
    endtask

    // Start a transfer; the expected bus cycles come straight from the copy rule.
    task automatic trigger(input logic [7:0] s);
        logic [15:0] sa;
        cpu_write(16'hFF46, s);
        exp_q.delete();
        for (int i = 0; i < 160; i++) begin
            sa = {fold(s), 8'(i)};
            exp_q.push_back('{addr: sa, we: 1'b0, data: 8'h00});
            exp_q.push_back('{addr: 16'(16'hFE00 + i), we: 1'b1, data: model[sa]});
        end
        $display("trigger src=%02h eff=%02h", s, fold(s));
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while (dma_busy && n < 1000) begin
            @(posedge clk); #1;
            n++;
        end
        check({name, "_done"}, dma_busy, 1'b0);
    endtask

    task automatic check_oam(input string name);
        int errs = 0;
        for (int i = 0; i < 160; i++)
            if (mem[16'(16'hFE00 + i)] !== model[16'(16'hFE00 + i)]) errs++;
        check(name, errs, 0);
        check({name, "_queue_empty"}, exp_q.size(), 0);
    endtask

    // START dead cycle, then the first source read one cycle later.
    task automatic check_start(input logic [7:0] s);
        check("start_busy", {dma_busy, cpu_mem_disable}, 2'b11);
        check("start_no_strobe", {bus_we, bus_re}, 2'b00);
        @(posedge clk); #1;
        check("first_read_re", bus_re, 1'b1);
        check("first_read_addr", bus_addr, {fold(s), 8'h00});
    endtask

    initial begin
        int b0, k, step, r;
        logic [7:0] s1, s2;
        logic [7:0] srcs [0:3];
        srcs[0] = 8'hC0; srcs[1] = 8'hC1; srcs[2] = 8'hD0; srcs[3] = 8'hE1;

        rst = 1'b1; cpu_addr = 16'h0000; cpu_wdata = 8'h00; cpu_we = 1'b0; cpu_re = 1'b0;

        fork
            forever begin
                bus_op_t op;
                @(negedge clk);
                if (dma_busy) busy_total++;
                if (!rst && dma_busy && (bus_we || bus_re)) begin
                    if (bus_addr[15:8] == 8'hE1) e1_seen++;
                    if (exp_q.size() == 0) begin
                        check("unexpected_strobe", exp_q.size(), 1);
                    end else begin
                        op = exp_q.pop_front();
                        check("strobe_kind", {bus_we, bus_re}, op.we ? 2'b10 : 2'b01);
                        check("strobe_addr", bus_addr, op.addr);
                        if (op.we) begin
                            check("write_data", bus_wdata, op.data);
                            model[op.addr] = op.data;
                        end
                    end
                end
            end
        join_none

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Reset state
        check("reset_busy", {dma_busy, cpu_mem_disable}, 2'b00);
        check("reset_strobes", {bus_we, bus_re}, 2'b00);
        cpu_addr = 16'hFF46; cpu_re = 1'b1; #1;
        check("reset_src", cpu_rdata, 8'h00);
        @(posedge clk); #1; cpu_re = 1'b0;

        // Preload source pages and OAM through the idle pass-through path
        for (int i = 0; i < 160; i++) preload(16'(16'hC000 + i), 8'(i) ^ 8'h5A);
        for (int i = 0; i < 160; i++) preload(16'(16'hC100 + i), 8'($urandom));
        for (int i = 0; i < 160; i++) preload(16'(16'hD000 + i), 8'($urandom));
        for (int i = 0; i < 160; i++) preload(16'(16'hFE00 + i), 8'($urandom));
        preload(16'hFF44, 8'h91);
        $display("preload done");

        // Idle pass-through
        cpu_addr = 16'hFF44; cpu_re = 1'b1; #1;
        check("pass_addr", bus_addr, 16'hFF44);
        check("pass_re", bus_re, 1'b1);
        check("pass_rdata", cpu_rdata, model[16'hFF44]);
        @(posedge clk); #1; cpu_re = 1'b0;

        // Basic copy with CPU lockout probes
        b0 = busy_total;
        trigger(8'hC0);
        check_start(8'hC0);
        cpu_addr = 16'hC000; cpu_re = 1'b1; #1;
        check("lock_read_ff", cpu_rdata, 8'hFF);
        @(posedge clk); #1;
        cpu_addr = 16'hFF46; #1;
        check("lock_read_dma", cpu_rdata, 8'hC0);
        @(posedge clk); #1;
        cpu_re = 1'b0;
        cpu_write(16'hC000, 8'h33);
        wait_idle("basic");
        check("basic_busy_cycles", busy_total - b0, 321);
        check_oam("basic_oam");
        check("lock_write_dropped", mem[16'hC000], model[16'hC000]);
        $display("basic copy done");

        // Echo mapping
        b0 = busy_total;
        e1_seen = 0;
        trigger(8'hE1);
        check_start(8'hE1);
        wait_idle("echo");
        check("echo_busy_cycles", busy_total - b0, 321);
        check("echo_no_e1_addr", e1_seen, 0);
        check_oam("echo_oam");
        $display("echo copy done");

        // Restart during the WRITE of idx 50, then a few random restart points
        for (int t = 0; t < 4; t++) begin
            if (t == 0) begin
                s1 = 8'hC0; s2 = 8'hD0; k = 50; step = 1;
            end else begin
                s1 = srcs[$urandom_range(0, 3)];
                s2 = srcs[$urandom_range(0, 3)];
                k = $urandom_range(0, 159);
                step = $urandom_range(0, 1);
            end
            r = 2 + 2 * k + step;
            b0 = busy_total;
            trigger(s1);
            repeat (r - 1) begin
                @(posedge clk); #1;
            end
            trigger(s2);
            check("restart_start", {bus_we, bus_re, dma_busy}, 3'b001);
            wait_idle("restart");
            check("restart_busy_cycles", busy_total - b0, r + 321);
            check_oam("restart_oam");
            $display("restart %02h->%02h at idx=%0d step=%0d busy=%0d", s1, s2, k, step, busy_total - b0);
        end

        // Asynchronous reset in the READ of byte 20
        trigger(8'hC1);
        repeat (41) begin
            @(posedge clk); #1;
        end
        rst = 1'b1; #1;
        check("rst_mid_busy", {dma_busy, cpu_mem_disable}, 2'b00);
        check("rst_mid_strobes", {bus_we, bus_re}, 2'b00);
        @(posedge clk); #1;
        rst = 1'b0;
        exp_q.delete();
        @(posedge clk); #1;
        check("rst_after_busy", cpu_mem_disable, 1'b0);
        check("rst_after_strobes", {bus_we, bus_re}, 2'b00);
        check_oam("rst_oam_partial");
        check("rst_byte19_new", mem[16'hFE13], mem[16'hC113]);
        cpu_addr = 16'hFF46; cpu_re = 1'b1; #1;
        check("rst_src_cleared", cpu_rdata, 8'h00);
        @(posedge clk); #1; cpu_re = 1'b0;
        $display("reset mid-transfer done");

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/oam_dma_arbiter.md
# oam_dma_arbiter

Owns the shared external address/data bus and sequences OAM DMA transfers on it. A CPU write to the DMA register (0xFF46) starts a 160-byte copy from `{src,8'h00}` to `0xFE00`. During the copy the block takes the bus from the CPU and returns idle data for CPU bus reads. It sits between the CPU memory port and the bus decode (WRAM, VRAM/OAM, cartridge, MMIO tristates) in the `gameboy` top level.

## Interface
Parameters:
- `LEN`, 160, bytes per transfer.
- `OAM_BASE`, 16'hFE00, destination base address.

Ports:
- `clk` in 1: system clock (4.19 MHz domain).
- `rst` in 1: reset, asynchronous, active-high.
- `cpu_addr` in 16: CPU address.
- `cpu_wdata` in 8: CPU write data.
- `cpu_we` in 1: CPU write strobe.
- `cpu_re` in 1: CPU read strobe.
- `bus_rdata` in 8: data returned by the bus decode.
- `bus_addr` out 16: address to the bus decode.
- `bus_wdata` out 8: write data to the bus.
- `bus_we` out 1: bus write strobe.
- `bus_re` out 1: bus read strobe.
- `cpu_rdata` out 8: read data returned to the CPU.
- `cpu_mem_disable` out 1: high while DMA owns the bus.
- `dma_busy` out 1: transfer in progress (status/debug).

## Operation
- States: IDLE, START, READ, WRITE.
- **IDLE:**
  - `bus_*` mirror `cpu_*` combinationally.
  - `cpu_rdata` = `bus_rdata`, except a read of 0xFF46 returns `src_reg`.
- **Trigger:** `cpu_we` with `cpu_addr==16'hFF46`, in any state.
  - Latch `src_reg <= cpu_wdata`.
  - Set `idx <= 0` and go to START.
  - This write is also forwarded on the bus in IDLE; it is not forwarded when busy.
- **Source mapping:**
  - Effective high byte = `src_reg >= 8'hE0 ? src_reg - 8'h20 : src_reg` (echo folds onto WRAM).
  - Computed combinationally from `src_reg`.
- **START:** one dead cycle; bus is idle (`bus_we = bus_re = 0`), then go to READ.
- **READ:**
  - `bus_addr = {src_eff, idx}`, `bus_re = 1`.
  - `data_reg <= bus_rdata` at the clock edge; go to WRITE.
- **WRITE:**
  - `bus_addr = OAM_BASE + idx`, `bus_wdata = data_reg`, `bus_we = 1`.
  - If `idx == LEN-1`, go to IDLE; else `idx <= idx+1` and go to READ.
- **While busy (START/READ/WRITE):**
  - CPU bus accesses are not forwarded.
  - CPU reads return 8'hFF, except 0xFF46, which returns `src_reg`.
  - CPU writes are dropped, except 0xFF46.
  - CPU-internal high memory (0xFF80–0xFFFE) is unaffected.
- **Restart:** a 0xFF46 write while busy wins over the current step. The current step's bus strobe still completes that cycle; the next state is START with the new source and `idx = 0`.
- **Width rules:**
  - `idx` is 8 bits; it never exceeds `LEN-1`.
  - `OAM_BASE + idx` is a 16-bit add, no carry beyond 0xFE9F.

## Timing
- Trigger write in cycle N, then:
  - START at N+1.
  - Byte i READ at N+2+2i, WRITE at N+3+2i.
  - Last OAM write (0xFE9F) at N+321.
  - IDLE at N+322.
- `dma_busy` and `cpu_mem_disable` are registered, derived from state ≠ IDLE. They are high from N+1 through N+321 and low at N+322.
- Read data is sampled on the READ-cycle edge, which requires a bus decode with same-cycle read data. Block RAMs with 1-cycle latency must be registered upstream.
- Reset values:
  - State IDLE; `src_reg = 8'h00`; `idx = 0`; `data_reg = 8'h00`.
  - `dma_busy = 0`, `cpu_mem_disable = 0`.
  - With `cpu_*` inactive: `bus_we = 0`, `bus_re = 0`.
- Reset mid-transfer: immediate return to IDLE; no further bus strobes; the partially written OAM is left as is.

## Structure
- Shared package `gb_mmio_pkg`:
  - `MMIO_DMA` (16'hFF46), `MEM_OAM_START` (16'hFE00), `OAM_LEN` (160).
  - `HRAM_START`/`HRAM_END`.
  - Enum `dma_state_t {IDLE, START, READ, WRITE}`.
- Single module, no sub-modules. The sequencer, mux and counter are under 250 lines.

## Test plan
- **Basic copy:** preload 0xC000–0xC09F with pattern i^8'h5A; write 0xFF46 = 8'hC0 → OAM 0xFE00–0xFE9F matches; `dma_busy` high for exactly 321 cycles.
- **Echo mapping:** write 0xFF46 = 8'hE1 → reads come from 0xC100–0xC19F; `bus_addr` never shows 0xE1xx.
- **CPU lockout:** during busy, a CPU read of 0xC000 returns 8'hFF with no `bus_re`. A CPU write to 0xC000 produces no `bus_we`, and memory is unchanged.
- **Restart:**
  - First transfer: write 0xFF46 = 8'hC0, and at idx = 50 write 0xFF46 = 8'hD0.
  - Expect START next cycle, then reads from 0xD000.
  - 0xFE32+ end with D0-page data; total busy = 51·2 + 1 + 321 cycles.
- **Reset mid-transfer:** assert `rst` at byte 20 → next edge IDLE; `cpu_mem_disable` = 0; OAM bytes 0–19 written, 21+ untouched; a read of 0xFF46 returns 8'h00.
- **Idle pass-through:** CPU read of 0xFF44 → `bus_addr` = 0xFF44, `bus_re` = 1, `cpu_rdata` = `bus_rdata` in the same cycle.
